// File: rtl/tablero_scanner.sv
// tablero_scanner: row-major board scan that tallies cell states and flags game over
module tablero_scanner #(
   parameter int FILAS = 5,
   parameter int COLS  = 5,
   localparam int RW = (FILAS > 1) ? $clog2(FILAS) : 1,
   localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int CW = $clog2(FILAS * COLS + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           cell_rd_en,
   output logic [RW-1:0]  cell_row,
   output logic [CLW-1:0] cell_col,
   input  logic [1:0]     cell_data,
   output logic [CW-1:0]  cnt_agua,
   output logic [CW-1:0]  cnt_barco,
   output logic [CW-1:0]  cnt_fallado,
   output logic [CW-1:0]  cnt_acertado,
   output logic           game_over
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_next;
   logic [RW-1:0] r_row;
   logic [CLW-1:0] r_col;
   logic r_vld;
   logic [CW-1:0] r_acc [4];
   logic [CW-1:0] w_acc [4];
   logic [CW-1:0] r_cnt [4];
   logic r_go;
   logic w_last;
   assign w_last = (r_row == RW'(FILAS - 1)) && (r_col == CLW'(COLS - 1));
   assign cell_row = r_row;
   assign cell_col = r_col;
   assign cnt_agua = r_cnt[0];
   assign cnt_barco = r_cnt[1];
   assign cnt_fallado = r_cnt[2];
   assign cnt_acertado = r_cnt[3];
   assign game_over = r_go;
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   // next-state logic; start only matters in IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_READ : S_IDLE;
         S_READ:  w_next = w_last ? S_DRAIN : S_READ;
         S_DRAIN: w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   // state-decoded outputs
   always_comb begin
      busy = r_state != S_IDLE;
      done = r_state == S_DONE;
      cell_rd_en = r_state == S_READ;
   end
   // accumulators including the cell whose data is arriving this cycle
   always_comb begin
      for (int k = 0; k < 4; k++) w_acc[k] = r_acc[k] + CW'(r_vld && cell_data == 2'(k));
   end
   // address walk, accumulation and result capture on DONE entry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= 1'b0;
         r_row <= '0;
         r_col <= '0;
         r_go <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            r_acc[k] <= '0;
            r_cnt[k] <= '0;
         end
      end else begin
         r_vld <= cell_rd_en;
         for (int k = 0; k < 4; k++) r_acc[k] <= (r_state == S_IDLE && start) ? '0 : w_acc[k];
         if (r_state == S_IDLE && start) begin
            r_row <= '0;
            r_col <= '0;
         end else if (r_state == S_READ) begin
            r_col <= (r_col == CLW'(COLS - 1)) ? '0 : r_col + CLW'(1);
            r_row <= w_last ? '0 : (r_col == CLW'(COLS - 1)) ? r_row + RW'(1) : r_row;
         end
         if (r_state == S_DRAIN) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= w_acc[k];
            r_go <= (w_acc[1] == '0) && (w_acc[3] != '0);
         end
      end
   end
endmodule

// File: doc/tablero_scanner.md
TABLERO_SCANNER -- requirements
Module: tablero_scanner

Interface
REQ-001 The module SHALL have parameter FILAS, default 5, giving the number of board rows.
REQ-002 The module SHALL have parameter COLS, default 5, giving the number of board columns.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  scan request, sampled only in IDLE.
REQ-007 Port busy  output  1  high in every non-IDLE state.
REQ-008 Port done  output  1  one-cycle pulse marking new results.
REQ-009 Port cell_rd_en  output  1  read strobe to the board storage.
REQ-010 Port cell_row  output  $clog2(FILAS)  row address of the current read.
REQ-011 Port cell_col  output  $clog2(COLS)  column address of the current read.
REQ-012 Port cell_data  input  2  cell state, valid exactly one cycle after cell_rd_en: 00 AGUA, 01 BARCO, 10 TIRO_FALLADO, 11 TIRO_ACERTADO.
REQ-013 Ports cnt_agua, cnt_barco, cnt_fallado, cnt_acertado  output  $clog2(FILAS*COLS+1) each  per-state cell counts of the last completed scan.
REQ-014 Port game_over  output  1  high when the last scan found cnt_barco==0 and cnt_acertado!=0.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-016 In IDLE with start=1, the FSM SHALL move to READ, clear the internal accumulators and set the address to (0,0).
REQ-017 In READ, cell_rd_en SHALL be 1 every cycle and the address SHALL advance in row-major order: col+1, and after col=COLS-1, col wraps to 0 and row+1.
REQ-018 After issuing address (FILAS-1,COLS-1), the FSM SHALL move to DRAIN for exactly one cycle with cell_rd_en=0.
REQ-019 An internal read-valid flag (cell_rd_en delayed 1 cycle) SHALL gate accumulation, so each cell is counted exactly once, including the last one captured in DRAIN.
REQ-020 Each accumulated cell SHALL increment exactly one of the four accumulators, selected by cell_data.
REQ-021 On entry to DONE, the four count outputs and game_over SHALL be loaded from the accumulators on the same edge that raises done.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-023 Timing: if start is sampled high at edge T, cell_rd_en SHALL be high for cycles T+1..T+FILAS*COLS, and done SHALL be high in cycle T+FILAS*COLS+2 (T+27 at the defaults).
REQ-024 Count outputs and game_over SHALL hold their values between scans and change only on DONE entry or reset.
REQ-025 start SHALL be ignored in READ, DRAIN and DONE; no request is queued.
REQ-026 If start is held high continuously, a new scan SHALL begin at the first IDLE cycle after DONE.
REQ-027 cell_row and cell_col SHALL be 0 in IDLE, DRAIN and DONE.
REQ-028 After every scan, the four counts SHALL sum to FILAS*COLS; the accumulators SHALL NOT wrap.

Reset
REQ-029 With rst=1 at an edge, the next state SHALL be IDLE, with busy=0, done=0, cell_rd_en=0, row=col=0, all counts 0 and game_over=0.
REQ-030 Reset asserted mid-scan SHALL abort the scan with no done pulse and no update of the count outputs except clearing them.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification
REQ-032 Board all 10 (the freshly filled board), start at T -> done at T+27, cnt_fallado=25, all other counts 0, game_over=0.
REQ-033 BARCO at (0,0),(2,3),(4,4), rest AGUA -> cnt_barco=3, cnt_agua=22, game_over=0; the address trace is (0,0),(0,1)..(4,4) across 25 consecutive cycles.
REQ-034 Those same three cells set to ACERTADO, rest AGUA -> cnt_acertado=3, cnt_agua=22, game_over=1; an all-AGUA board -> cnt_agua=25, game_over=0.
REQ-035 start re-pulsed at T+10 -> ignored, single done at T+27; start held high -> the second scan's first cell_rd_en is at T+29.
REQ-036 rst at T+12 of a scan -> IDLE at T+13, cell_rd_en=0, counts 0, no done; a following scan produces correct counts.
